// File: rtl/uart_fb_loader_if.sv
// Frame-buffer row write port between uart_fb_loader and the frame buffer.
//   fb_we      : one-cycle row write strobe
//   fb_addr    : row index of the current write
//   fb_wdata   : row pixel data, bit0 = column 0
//   frame_done : one-cycle pulse alongside the write of the last row
// master = loader side (drives), slave = frame buffer side (receives).
interface uart_fb_loader_if;
  logic       fb_we;
  logic [2:0] fb_addr;
  logic [7:0] fb_wdata;
  logic       frame_done;

  modport master (output fb_we, output fb_addr, output fb_wdata, output frame_done);
  modport slave  (input  fb_we, input  fb_addr, input  fb_wdata, input  frame_done);
endinterface

// File: rtl/uart_fb_loader.sv
// uart_fb_loader: recovers 8N1 bytes from the host UART line and converts
// them into frame-buffer row writes.
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-low
//   uart_data   : UART RX line, idle high, asynchronous to clk
//   fb          : row write port (master side of uart_fb_loader_if)
//   framing_err : one-cycle pulse when a stop bit is sampled low
// Byte stream: a header 8'b11110_rrr selects the start row, each following
// data byte fills one row, and the frame ends after row ROWS-1.
module uart_fb_loader #(
  parameter int CLKS_PER_BIT = 20,
  parameter int ROWS         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_data,
  uart_fb_loader_if.master  fb,
  output logic              framing_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_ROW = 3'(ROWS - 1);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  localparam logic P_HUNT = 1'b0;
  localparam logic P_LOAD = 1'b1;

  logic          s1_reg, s2_reg;
  logic [2:0]    rx_state_reg;
  logic [CW-1:0] cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic [7:0]    rx_byte_reg;
  logic          rx_valid_reg;
  logic          framing_err_reg;

  logic          p_state_reg;
  logic [2:0]    row_reg;
  logic [2:0]    addr_reg;
  logic [7:0]    wdata_reg;
  logic          we_reg;
  logic          frame_done_reg;

  logic          is_hdr;
  logic          hdr_ok;

  // ---------------- receiver ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg          <= 1'b1;
      s2_reg          <= 1'b1;
      rx_state_reg    <= RX_IDLE;
      cnt_reg         <= '0;
      bit_idx_reg     <= 3'd0;
      shift_reg       <= 8'd0;
      rx_byte_reg     <= 8'd0;
      rx_valid_reg    <= 1'b0;
      framing_err_reg <= 1'b0;
    end else begin
      s1_reg          <= uart_data;
      s2_reg          <= s1_reg;
      rx_valid_reg    <= 1'b0;
      framing_err_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (!s2_reg) begin
            rx_state_reg <= RX_START;
            cnt_reg      <= '0;
          end
        end
        RX_START: begin
          // Re-check the line at the middle of the start bit so short
          // low glitches fall back to idle silently.
          if (cnt_reg == CNT_MID) begin
            cnt_reg     <= '0;
            bit_idx_reg <= 3'd0;
            rx_state_reg <= s2_reg ? RX_IDLE : RX_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_reg == CNT_END) begin
            cnt_reg   <= '0;
            shift_reg <= {s2_reg, shift_reg[7:1]};  // LSB arrives first
            if (bit_idx_reg == 3'd7) rx_state_reg <= RX_STOP;
            else                     bit_idx_reg  <= bit_idx_reg + 3'd1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_reg == CNT_END) begin
            cnt_reg <= '0;
            if (s2_reg) begin
              rx_valid_reg <= 1'b1;
              rx_byte_reg  <= shift_reg;
              rx_state_reg <= RX_IDLE;
            end else begin
              framing_err_reg <= 1'b1;
              rx_state_reg    <= RX_BREAK;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RX_BREAK: begin
          // A line held low reports one error, then waits for idle.
          if (s2_reg) rx_state_reg <= RX_IDLE;
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  // ---------------- parser ----------------
  assign is_hdr = (rx_byte_reg[7:3] == 5'b11110);
  assign hdr_ok = is_hdr && (int'(rx_byte_reg[2:0]) < ROWS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_state_reg    <= P_HUNT;
      row_reg        <= 3'd0;
      addr_reg       <= 3'd0;
      wdata_reg      <= 8'd0;
      we_reg         <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      we_reg         <= 1'b0;
      frame_done_reg <= 1'b0;
      // The visible address trails row_reg by one cycle, so it shows the
      // row being written during fb_we and the advanced row afterwards.
      addr_reg       <= row_reg;
      if (rx_valid_reg) begin
        if (is_hdr) begin
          if (hdr_ok) begin
            row_reg     <= rx_byte_reg[2:0];
            p_state_reg <= P_LOAD;
          end
        end else if (p_state_reg == P_LOAD) begin
          we_reg    <= 1'b1;
          wdata_reg <= rx_byte_reg;
          if (row_reg == LAST_ROW) begin
            frame_done_reg <= 1'b1;
            row_reg        <= 3'd0;
            p_state_reg    <= P_HUNT;
          end else begin
            row_reg <= row_reg + 3'd1;
          end
        end
      end else if (framing_err_reg) begin
        p_state_reg <= P_HUNT;
      end
    end
  end

  assign fb.fb_we      = we_reg;
  assign fb.fb_addr    = addr_reg;
  assign fb.fb_wdata   = wdata_reg;
  assign fb.frame_done = frame_done_reg;
  assign framing_err   = framing_err_reg;

endmodule

// File: tb/tb_uart_fb_loader.sv
module tb_uart_fb_loader;
  localparam int CPB = 20;
  localparam int LAT = 194;  // start-bit drive edge to fb_we, in clocks

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic uart_data = 1'b1;
  logic framing_err;
  uart_fb_loader_if fbi();

  uart_fb_loader #(.CLKS_PER_BIT(CPB), .ROWS(8)) dut (
    .clk(clk), .reset(reset), .uart_data(uart_data),
    .fb(fbi), .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int last_start = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  logic [2:0] q_addr[$];
  logic [7:0] q_data[$];
  logic       q_fd[$];
  int         q_lat[$];
  int         err_cnt = 0;
  int         stray_fd = 0;

  always @(negedge clk) begin
    if (fbi.fb_we === 1'b1) begin
      q_addr.push_back(fbi.fb_addr);
      q_data.push_back(fbi.fb_wdata);
      q_fd.push_back(fbi.frame_done);
      q_lat.push_back(cyc - last_start);
    end else if (fbi.frame_done === 1'b1) begin
      stray_fd++;
    end
    if (framing_err === 1'b1) err_cnt++;
  end

  task automatic clear_log();
    q_addr.delete(); q_data.delete(); q_fd.delete(); q_lat.delete();
    err_cnt = 0; stray_fd = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    uart_data = 1'b0;
    last_start = cyc;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_data = b[i];
      idle(CPB);
    end
    uart_data = stop_bit;
    idle(CPB);
    uart_data = 1'b1;
    idle(CPB);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(3);
    checks++;
    if ({fbi.fb_we, fbi.fb_addr, fbi.fb_wdata, fbi.frame_done, framing_err} !== 14'd0)
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h fd=%b err=%b, want all 0",
               fbi.fb_we, fbi.fb_addr, fbi.fb_wdata, fbi.frame_done, framing_err);
    else passes++;
    reset = 1'b1;
    clear_log();
    idle(500);
    checks++;
    if (q_addr.size() != 0 || err_cnt != 0 || stray_fd != 0)
      $display("FAIL idle_line: got writes=%0d errs=%0d stray_fd=%0d, want 0/0/0",
               q_addr.size(), err_cnt, stray_fd);
    else passes++;
    checks++;
    if (fbi.fb_addr !== 3'd0 || fbi.fb_wdata !== 8'd0)
      $display("FAIL idle_outputs: got addr=%0d data=%h, want 0/00", fbi.fb_addr, fbi.fb_wdata);
    else passes++;
    $display("test_reset: done");
  endtask

  task automatic test_full_frame();
    logic [7:0] exp_d;
    clear_log();
    send_byte(8'hF0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_d = 8'(1 << i);
      send_byte(exp_d, 1'b1);
    end
    checks++;
    if (q_addr.size() != 8)
      $display("FAIL full_count: got %0d writes, want 8", q_addr.size());
    else passes++;
    for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
      exp_d = 8'(1 << i);
      checks++;
      if (q_addr[i] !== 3'(i) || q_data[i] !== exp_d || q_fd[i] !== (i == 7) || q_lat[i] != LAT)
        $display("FAIL full_row%0d: got addr=%0d data=%h fd=%b lat=%0d, want addr=%0d data=%h fd=%b lat=%0d",
                 i, q_addr[i], q_data[i], q_fd[i], q_lat[i], i, exp_d, (i == 7), LAT);
      else passes++;
    end
    checks++;
    if (fbi.fb_addr !== 3'd0 || fbi.fb_wdata !== 8'h80 || stray_fd != 0)
      $display("FAIL full_after: got addr=%0d data=%h stray_fd=%0d, want 0/80/0",
               fbi.fb_addr, fbi.fb_wdata, stray_fd);
    else passes++;
    $display("test_full_frame: %0d writes", q_addr.size());
  endtask

  task automatic test_partial_start();
    logic [7:0] bytes [5] = '{8'hF5, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [2:0] ea [3] = '{3'd5, 3'd6, 3'd7};
    logic [7:0] ed [3] = '{8'hAA, 8'hBB, 8'hCC};
    clear_log();
    foreach (bytes[k]) send_byte(bytes[k], 1'b1);
    checks++;
    if (q_addr.size() != 3)
      $display("FAIL partial_count: got %0d writes, want 3", q_addr.size());
    else passes++;
    for (int i = 0; i < 3 && i < q_addr.size(); i++) begin
      checks++;
      if (q_addr[i] !== ea[i] || q_data[i] !== ed[i] || q_fd[i] !== (i == 2))
        $display("FAIL partial_row%0d: got addr=%0d data=%h fd=%b, want addr=%0d data=%h fd=%b",
                 i, q_addr[i], q_data[i], q_fd[i], ea[i], ed[i], (i == 2));
      else passes++;
    end
    $display("test_partial_start: %0d writes", q_addr.size());
  endtask

  task automatic test_framing_error();
    clear_log();
    send_byte(8'h55, 1'b0);
    checks++;
    if (err_cnt != 1 || q_addr.size() != 0)
      $display("FAIL framing_pulse: got errs=%0d writes=%0d, want 1/0", err_cnt, q_addr.size());
    else passes++;
    clear_log();
    send_byte(8'hF0, 1'b1);
    send_byte(8'h3C, 1'b1);
    checks++;
    if (q_addr.size() != 1 || err_cnt != 0)
      $display("FAIL framing_recover_count: got writes=%0d errs=%0d, want 1/0", q_addr.size(), err_cnt);
    else if (q_addr[0] !== 3'd0 || q_data[0] !== 8'h3C || q_fd[0] !== 1'b0)
      $display("FAIL framing_recover: got addr=%0d data=%h fd=%b, want 0/3c/0", q_addr[0], q_data[0], q_fd[0]);
    else passes++;
    $display("test_framing_error: done");
  endtask

  task automatic test_glitch();
    clear_log();
    @(posedge clk); #1;
    uart_data = 1'b0;
    idle(CPB / 4);
    uart_data = 1'b1;
    idle(100);
    checks++;
    if (err_cnt != 0 || q_addr.size() != 0)
      $display("FAIL glitch_reject: got errs=%0d writes=%0d, want 0/0", err_cnt, q_addr.size());
    else passes++;
    send_byte(8'hF3, 1'b1);
    send_byte(8'hA5, 1'b1);
    checks++;
    if (q_addr.size() != 1 || err_cnt != 0)
      $display("FAIL glitch_next_count: got writes=%0d errs=%0d, want 1/0", q_addr.size(), err_cnt);
    else if (q_addr[0] !== 3'd3 || q_data[0] !== 8'hA5 || q_lat[0] != LAT)
      $display("FAIL glitch_next: got addr=%0d data=%h lat=%0d, want 3/a5/%0d", q_addr[0], q_data[0], q_lat[0], LAT);
    else passes++;
    $display("test_glitch: done");
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b;
    b = 8'h77;
    clear_log();
    send_byte(8'hF2, 1'b1);
    @(posedge clk); #1;
    uart_data = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_data = b[i];
      idle(CPB);
    end
    reset = 1'b0;
    uart_data = 1'b1;
    idle(5);
    checks++;
    if ({fbi.fb_we, fbi.fb_addr, fbi.fb_wdata, fbi.frame_done, framing_err} !== 14'd0)
      $display("FAIL midreset_outputs: got we=%b addr=%0d data=%h fd=%b err=%b, want all 0",
               fbi.fb_we, fbi.fb_addr, fbi.fb_wdata, fbi.frame_done, framing_err);
    else passes++;
    reset = 1'b1;
    idle(40);
    send_byte(8'h77, 1'b1);
    checks++;
    if (q_addr.size() != 0 || err_cnt != 0)
      $display("FAIL midreset_hunt: got writes=%0d errs=%0d, want 0/0", q_addr.size(), err_cnt);
    else passes++;
    send_byte(8'hF2, 1'b1);
    send_byte(8'h77, 1'b1);
    checks++;
    if (q_addr.size() != 1)
      $display("FAIL midreset_reload_count: got %0d writes, want 1", q_addr.size());
    else if (q_addr[0] !== 3'd2 || q_data[0] !== 8'h77)
      $display("FAIL midreset_reload: got addr=%0d data=%h, want 2/77", q_addr[0], q_data[0]);
    else passes++;
    checks++;
    if (fbi.fb_addr !== 3'd3 || fbi.fb_wdata !== 8'h77)
      $display("FAIL midreset_hold: got addr=%0d data=%h, want 3/77", fbi.fb_addr, fbi.fb_wdata);
    else passes++;
    $display("test_reset_mid_byte: done");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_partial_start();
    test_framing_error();
    test_glitch();
    test_reset_mid_byte();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
